// File: rtl/recon_dma_engine.sv
// Reconfiguration DMA front end: parses a recon header from the first AXIS beat,
// issues read/write DMA descriptors and realigns write payload onto the output stream.
module recon_dma_engine #(
  parameter int          DATA_WIDTH = 512,
  parameter int          ADDR_WIDTH = 34,
  parameter int          LEN_WIDTH  = 20,
  parameter int          TAG_WIDTH  = 8,
  parameter int          HDR_OFFSET = 46,
  parameter logic [15:0] MAGIC      = 16'hF0E1,
  parameter int          NUM_SLOTS  = 4,
  localparam int         KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,

  output logic [ADDR_WIDTH-1:0] m_axis_read_desc_addr,
  output logic [LEN_WIDTH-1:0]  m_axis_read_desc_len,
  output logic [TAG_WIDTH-1:0]  m_axis_read_desc_tag,
  output logic                  m_axis_read_desc_valid,
  input  logic                  m_axis_read_desc_ready,

  output logic [ADDR_WIDTH-1:0] m_axis_write_desc_addr,
  output logic [LEN_WIDTH-1:0]  m_axis_write_desc_len,
  output logic [TAG_WIDTH-1:0]  m_axis_write_desc_tag,
  output logic                  m_axis_write_desc_valid,
  input  logic                  m_axis_write_desc_ready,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,

  output logic [15:0]           stat_good_count,
  output logic [15:0]           stat_drop_count,
  output logic                  err_short
);

  localparam int          PAYLOAD_OFFSET = HDR_OFFSET + 13;
  localparam int          P1             = KEEP_WIDTH - PAYLOAD_OFFSET;
  localparam logic [31:0] P1_U           = 32'(P1);
  localparam logic [31:0] KW_U           = 32'(KEEP_WIDTH);

  if (PAYLOAD_OFFSET > KEEP_WIDTH) begin : g_bad_hdr_offset
    $error("recon header does not fit inside the first beat");
  end
  if (NUM_SLOTS < 1 || NUM_SLOTS > 16) begin : g_bad_num_slots
    $error("NUM_SLOTS must be within 1..16");
  end
  if (ADDR_WIDTH > 40 || LEN_WIDTH > 32 || TAG_WIDTH > 8) begin : g_bad_field_width
    $error("descriptor field wider than its header field");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_DESC,
    S_PAYLOAD,
    S_FLUSH,
    S_DROP
  } state_t;

  state_t state, state_next;

  function automatic logic [KEEP_WIDTH-1:0] keep_mask(input logic [31:0] n);
    logic [KEEP_WIDTH-1:0] m;
    for (int i = 0; i < KEEP_WIDTH; i++) m[i] = (32'(i) < n);
    return m;
  endfunction

  // Header fields, little-endian, relative to HDR_OFFSET
  logic [15:0]           hdr_magic;
  logic [1:0]            hdr_func;
  logic [3:0]            hdr_slot;
  logic [ADDR_WIDTH-1:0] hdr_addr;
  logic [LEN_WIDTH-1:0]  hdr_len;
  logic [TAG_WIDTH-1:0]  hdr_tag;

  assign hdr_magic = s_axis_tdata[HDR_OFFSET*8 +: 16];
  assign hdr_func  = s_axis_tdata[(HDR_OFFSET+2)*8 +: 2];
  assign hdr_slot  = s_axis_tdata[(HDR_OFFSET+2)*8+4 +: 4];
  assign hdr_addr  = s_axis_tdata[(HDR_OFFSET+3)*8 +: ADDR_WIDTH];
  assign hdr_len   = s_axis_tdata[(HDR_OFFSET+8)*8 +: LEN_WIDTH];
  assign hdr_tag   = s_axis_tdata[(HDR_OFFSET+12)*8 +: TAG_WIDTH];

  // Frame length is tracked by the header, so input tkeep carries no information here
  logic unused_tkeep;
  assign unused_tkeep = ^s_axis_tkeep;

  logic [ADDR_WIDTH-1:0] slot_addr  [NUM_SLOTS];
  logic [LEN_WIDTH-1:0]  slot_len   [NUM_SLOTS];
  logic                  slot_valid [NUM_SLOTS];

  logic [ADDR_WIDTH-1:0] slot_rd_addr;
  logic [LEN_WIDTH-1:0]  slot_rd_len;
  logic                  slot_rd_ok;

  always_comb begin
    slot_rd_addr = '0;
    slot_rd_len  = '0;
    slot_rd_ok   = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (hdr_slot == 4'(i)) begin
        slot_rd_addr = slot_addr[i];
        slot_rd_len  = slot_len[i];
        slot_rd_ok   = slot_valid[i];
      end
    end
  end

  logic hdr_bad;
  assign hdr_bad = (hdr_magic != MAGIC) || (hdr_func == 2'b11) || (hdr_len == '0) ||
                   ((hdr_func == 2'b10) && !slot_rd_ok);

  logic [LEN_WIDTH-1:0]  rem;
  logic [DATA_WIDTH-1:0] saved;
  logic                  is_write;
  logic                  first_last;
  logic                  last_in;

  logic [31:0]           rem32;
  logic [31:0]           emit32;
  logic [LEN_WIDTH-1:0]  rem_after;
  logic                  out_free;
  logic [KEEP_WIDTH-1:0] pay_keep;
  logic                  pay_last;
  logic [KEEP_WIDTH-1:0] flush_keep;

  assign rem32      = 32'(rem);
  assign emit32     = (rem32 <= KW_U) ? rem32 : KW_U;
  assign rem_after  = LEN_WIDTH'(rem32 - emit32);
  assign out_free   = !m_axis_tvalid || m_axis_tready;
  assign pay_last   = (rem32 <= KW_U);
  assign pay_keep   = pay_last ? keep_mask(rem32) : '1;
  assign flush_keep = keep_mask((rem32 < P1_U) ? rem32 : P1_U);

  logic s_ready_int;
  logic hdr_accept;
  logic hdr_drop_evt;
  logic desc_done;
  logic pay_fire;
  logic flush_fire;
  logic short_evt;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    s_ready_int  = 1'b0;
    hdr_accept   = 1'b0;
    hdr_drop_evt = 1'b0;
    desc_done    = 1'b0;
    pay_fire     = 1'b0;
    flush_fire   = 1'b0;
    short_evt    = 1'b0;
    case (state)
      S_IDLE: begin
        s_ready_int = 1'b1;
        if (s_axis_tvalid) begin
          if (hdr_bad) begin
            hdr_drop_evt = 1'b1;
            state_next   = s_axis_tlast ? S_IDLE : S_DROP;
          end else begin
            hdr_accept = 1'b1;
            state_next = S_DESC;
          end
        end
      end
      S_DESC: begin
        if (is_write) begin
          if (m_axis_write_desc_ready) begin
            desc_done = 1'b1;
            // Single-beat write frames go straight to emitting the saved bytes
            if (first_last || rem32 <= P1_U) begin
              short_evt  = first_last && (rem32 > P1_U);
              state_next = S_FLUSH;
            end else begin
              state_next = S_PAYLOAD;
            end
          end
        end else if (m_axis_read_desc_ready) begin
          desc_done  = 1'b1;
          state_next = first_last ? S_IDLE : S_DROP;
        end
      end
      S_PAYLOAD: begin
        s_ready_int = out_free;
        if (s_axis_tvalid && out_free) begin
          pay_fire = 1'b1;
          if (rem_after == '0) begin
            state_next = s_axis_tlast ? S_IDLE : S_DROP;
          end else if (32'(rem_after) <= P1_U) begin
            state_next = S_FLUSH;
          end else if (s_axis_tlast) begin
            short_evt  = 1'b1;
            state_next = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (out_free) begin
          flush_fire = 1'b1;
          state_next = last_in ? S_IDLE : S_DROP;
        end
      end
      S_DROP: begin
        s_ready_int = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign s_axis_tready = s_ready_int && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_read_desc_addr   <= '0;
      m_axis_read_desc_len    <= '0;
      m_axis_read_desc_tag    <= '0;
      m_axis_read_desc_valid  <= 1'b0;
      m_axis_write_desc_addr  <= '0;
      m_axis_write_desc_len   <= '0;
      m_axis_write_desc_tag   <= '0;
      m_axis_write_desc_valid <= 1'b0;
      m_axis_tdata            <= '0;
      m_axis_tkeep            <= '0;
      m_axis_tvalid           <= 1'b0;
      m_axis_tlast            <= 1'b0;
      stat_good_count         <= '0;
      stat_drop_count         <= '0;
      err_short               <= 1'b0;
      rem                     <= '0;
      saved                   <= '0;
      is_write                <= 1'b0;
      first_last              <= 1'b0;
      last_in                 <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_addr[i]  <= '0;
        slot_len[i]   <= '0;
        slot_valid[i] <= 1'b0;
      end
    end else begin
      err_short <= short_evt;

      if (hdr_drop_evt && stat_drop_count != 16'hFFFF)
        stat_drop_count <= stat_drop_count + 16'd1;

      if (hdr_accept) begin
        first_last <= s_axis_tlast;
        is_write   <= (hdr_func == 2'b00);
        case (hdr_func)
          2'b00: begin
            m_axis_write_desc_addr  <= hdr_addr;
            m_axis_write_desc_len   <= hdr_len;
            m_axis_write_desc_tag   <= hdr_tag;
            m_axis_write_desc_valid <= 1'b1;
            rem                     <= hdr_len;
            saved                   <= s_axis_tdata >> (PAYLOAD_OFFSET*8);
            for (int i = 0; i < NUM_SLOTS; i++) begin
              if (hdr_slot == 4'(i)) begin
                slot_addr[i]  <= hdr_addr;
                slot_len[i]   <= hdr_len;
                slot_valid[i] <= 1'b1;
              end
            end
          end
          2'b01: begin
            m_axis_read_desc_addr  <= hdr_addr;
            m_axis_read_desc_len   <= hdr_len;
            m_axis_read_desc_tag   <= hdr_tag;
            m_axis_read_desc_valid <= 1'b1;
          end
          default: begin
            m_axis_read_desc_addr  <= slot_rd_addr;
            m_axis_read_desc_len   <= slot_rd_len;
            m_axis_read_desc_tag   <= hdr_tag;
            m_axis_read_desc_valid <= 1'b1;
          end
        endcase
      end

      if (desc_done) begin
        m_axis_write_desc_valid <= 1'b0;
        m_axis_read_desc_valid  <= 1'b0;
        last_in                 <= first_last;
        if (stat_good_count != 16'hFFFF)
          stat_good_count <= stat_good_count + 16'd1;
      end

      if (m_axis_tvalid && m_axis_tready)
        m_axis_tvalid <= 1'b0;

      // Saved bytes fill the low end; the current beat's top P1 bytes carry into the next beat
      if (pay_fire) begin
        m_axis_tdata  <= (s_axis_tdata << (P1*8)) | saved;
        m_axis_tkeep  <= pay_keep;
        m_axis_tlast  <= pay_last;
        m_axis_tvalid <= 1'b1;
        saved         <= s_axis_tdata >> (PAYLOAD_OFFSET*8);
        rem           <= rem_after;
        last_in       <= s_axis_tlast;
      end else if (flush_fire) begin
        m_axis_tdata  <= saved;
        m_axis_tkeep  <= flush_keep;
        m_axis_tlast  <= 1'b1;
        m_axis_tvalid <= 1'b1;
        rem           <= '0;
      end
    end
  end

endmodule

// File: tb/tb_recon_dma_engine.sv
// Scoreboard bench for recon_dma_engine: frames are modelled at byte level and the
// expected descriptors / output beats are queued as each frame is driven.
module tb_recon_dma_engine;

  localparam int DW = 512;
  localparam int KW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic [33:0]   rd_addr, wr_addr;
  logic [19:0]   rd_len, wr_len;
  logic [7:0]    rd_tag, wr_tag;
  logic          rd_valid, wr_valid;
  logic          rd_ready, wr_ready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [15:0]   stat_good_count, stat_drop_count;
  logic          err_short;

  recon_dma_engine dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_read_desc_addr(rd_addr), .m_axis_read_desc_len(rd_len), .m_axis_read_desc_tag(rd_tag),
    .m_axis_read_desc_valid(rd_valid), .m_axis_read_desc_ready(rd_ready),
    .m_axis_write_desc_addr(wr_addr), .m_axis_write_desc_len(wr_len), .m_axis_write_desc_tag(wr_tag),
    .m_axis_write_desc_valid(wr_valid), .m_axis_write_desc_ready(wr_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .stat_good_count(stat_good_count), .stat_drop_count(stat_drop_count), .err_short(err_short)
  );

  typedef struct { logic [DW-1:0] data; logic [KW-1:0] keep; logic last; } beat_t;
  typedef struct { logic [33:0] addr; logic [19:0] len; logic [7:0] tag; } desc_t;

  beat_t out_q[$];
  desc_t wr_q[$];
  desc_t rd_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int exp_good, exp_drop, exp_short, short_seen;
  bit          tb_slot_valid [4];
  logic [33:0] tb_slot_addr  [4];
  logic [19:0] tb_slot_len   [4];
  logic [7:0]  pay_buf [8192];
  bit          bp_en = 1'b0;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
  endtask

  function automatic logic [KW-1:0] mask_n(input int n);
    logic [KW-1:0] m;
    for (int i = 0; i < KW; i++) m[i] = (i < n);
    return m;
  endfunction

  function automatic logic [DW-1:0] byte_expand(input logic [KW-1:0] k);
    logic [DW-1:0] m;
    for (int i = 0; i < KW; i++) m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction

  // Output-side backpressure, updated just after each active edge
  initial forever begin
    @(posedge clk);
    #1;
    m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (m_axis_tvalid && m_axis_tready) begin
        check_val("out_q_nonempty", DW'(out_q.size() != 0), DW'(1));
        if (out_q.size() != 0) begin
          beat_t e;
          e = out_q.pop_front();
          check_val("out_keep", DW'(m_axis_tkeep), DW'(e.keep));
          check_val("out_last", DW'(m_axis_tlast), DW'(e.last));
          check_val("out_data", m_axis_tdata & byte_expand(e.keep), e.data);
        end
      end
      if (wr_valid && wr_ready) begin
        check_val("wr_q_nonempty", DW'(wr_q.size() != 0), DW'(1));
        if (wr_q.size() != 0) begin
          desc_t d;
          d = wr_q.pop_front();
          check_val("wr_desc", DW'({wr_addr, wr_len, wr_tag}), DW'({d.addr, d.len, d.tag}));
        end
      end
      if (rd_valid && rd_ready) begin
        check_val("rd_q_nonempty", DW'(rd_q.size() != 0), DW'(1));
        if (rd_q.size() != 0) begin
          desc_t d;
          d = rd_q.pop_front();
          check_val("rd_desc", DW'({rd_addr, rd_len, rd_tag}), DW'({d.addr, d.len, d.tag}));
        end
      end
      if (err_short) short_seen++;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_s_tready", DW'(s_axis_tready), DW'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_q.delete(); wr_q.delete(); rd_q.delete();
    exp_good = 0; exp_drop = 0; exp_short = 0; short_seen = 0;
    for (int i = 0; i < 4; i++) tb_slot_valid[i] = 1'b0;
    check_val("rst_valids", DW'({m_axis_tvalid, wr_valid, rd_valid, err_short}), DW'(0));
    check_val("rst_counts", DW'({stat_good_count, stat_drop_count}), DW'(0));
    check_val("rst_fields", DW'({wr_addr, wr_len, wr_tag, rd_addr, rd_len, rd_tag}), DW'(0));
    check_val("rst_tdata", m_axis_tdata, '0);
  endtask

  // Drives one frame; when model=1 the expected results are queued first.
  task automatic send_frame(input int magic, input int func, input int slot, input longint addr,
                            input int len, input int tag, input int nbeats, input bit with_last,
                            input bit model, input int seed, output int accepted);
    int avail;
    logic [DW-1:0] d;
    accepted = 0;
    avail = 5 + 64 * (nbeats - 1);
    for (int i = 0; i < avail; i++) pay_buf[i] = 8'(seed + i * 13 + (i >> 5));
    if (model) begin
      bit drop;
      drop = (16'(magic) != 16'hF0E1) || (func == 3) || (20'(len) == 20'd0);
      if (func == 2) begin
        if (slot >= 4) drop = 1'b1;
        else if (!tb_slot_valid[slot]) drop = 1'b1;
      end
      if (drop) exp_drop++;
      else begin
        exp_good++;
        if (func == 0) begin
          int n;
          wr_q.push_back('{addr: 34'(addr), len: 20'(len), tag: 8'(tag)});
          if (slot < 4) begin
            tb_slot_valid[slot] = 1'b1;
            tb_slot_addr[slot]  = 34'(addr);
            tb_slot_len[slot]   = 20'(len);
          end
          n = (len < avail) ? len : avail;
          if (avail < len) exp_short++;
          for (int c = 0; c * 64 < n; c++) begin
            beat_t b;
            int sz;
            sz = (n - c * 64 < 64) ? n - c * 64 : 64;
            b.data = '0;
            for (int j = 0; j < sz; j++) b.data[j*8 +: 8] = pay_buf[c*64 + j];
            b.keep = mask_n(sz);
            b.last = (c * 64 + sz == n);
            out_q.push_back(b);
          end
        end else if (func == 1) begin
          rd_q.push_back('{addr: 34'(addr), len: 20'(len), tag: 8'(tag)});
        end else begin
          rd_q.push_back('{addr: tb_slot_addr[slot], len: tb_slot_len[slot], tag: 8'(tag)});
        end
      end
    end
    for (int b = 0; b < nbeats; b++) begin
      bit got;
      for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom();
      if (b == 0) begin
        d[46*8 +: 16] = 16'(magic);
        d[48*8 +: 8]  = {4'(slot), 2'b00, 2'(func)};
        d[49*8 +: 40] = 40'(addr);
        d[54*8 +: 32] = 32'(len);
        d[58*8 +: 8]  = 8'(tag);
        for (int j = 0; j < 5; j++) d[(59+j)*8 +: 8] = pay_buf[j];
        s_axis_tkeep = KW'({$urandom(), $urandom()});
      end else begin
        for (int j = 0; j < 64; j++) d[j*8 +: 8] = pay_buf[5 + 64*(b-1) + j];
        s_axis_tkeep = '1;
      end
      s_axis_tdata  = d;
      s_axis_tlast  = with_last && (b == nbeats - 1);
      s_axis_tvalid = 1'b1;
      got = 1'b0;
      for (int n = 0; n < 2000 && !got; n++) begin
        @(negedge clk);
        if (s_axis_tready) got = 1'b1;
      end
      if (!got) begin
        check_val("s_ready_timeout", DW'(0), DW'(1));
        s_axis_tvalid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      accepted++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (out_q.size() == 0 && wr_q.size() == 0 && rd_q.size() == 0) break;
    end
    check_val(tag, DW'(out_q.size() + wr_q.size() + rd_q.size()), DW'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input string tag);
    check_val({tag, "_good"}, DW'(stat_good_count), DW'(exp_good));
    check_val({tag, "_drop"}, DW'(stat_drop_count), DW'(exp_drop));
    check_val({tag, "_short"}, DW'(short_seen), DW'(exp_short));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct { int magic; int func; int slot; longint addr; int len; int tag; int nbeats; } frame_t;
  frame_t misc [7];

  initial begin
    int acc;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    wr_ready = 1'b1; rd_ready = 1'b1; m_axis_tready = 1'b1;
    do_reset();

    send_frame(16'hF0E1, 0, 0, 64'h2_1234_5678, 100, 8'h11, 3, 1'b1, 1'b1, 7, acc);
    wait_drain("drain_w100");
    check_stats("w100");

    send_frame(16'h1234, 0, 0, 64'h100, 100, 8'h22, 4, 1'b1, 1'b1, 9, acc);
    check_val("bad_magic_beats", DW'(acc), DW'(4));
    wait_drain("drain_magic");
    check_stats("magic");

    send_frame(16'hF0E1, 0, 2, 64'h1_0000_0000, 4096, 8'h33, 65, 1'b1, 1'b1, 3, acc);
    send_frame(16'hF0E1, 2, 2, 64'h0, 1, 8'h5A, 1, 1'b1, 1'b1, 4, acc);
    send_frame(16'hF0E1, 2, 3, 64'h0, 1, 8'h5B, 1, 1'b1, 1'b1, 5, acc);
    wait_drain("drain_slot");
    check_stats("slot");

    misc[0] = '{16'hF0E1, 3, 0, 64'h40, 16, 8'h01, 2};
    misc[1] = '{16'hF0E1, 0, 1, 64'h80, 0, 8'h02, 1};
    misc[2] = '{16'hF0E1, 2, 9, 64'h0, 8, 8'h03, 2};
    misc[3] = '{16'hF0E1, 0, 1, 64'h3_0000_0040, 3, 8'h04, 1};
    misc[4] = '{16'hF0E1, 0, 7, 64'h0_0ABC_0000, 69, 8'h05, 2};
    misc[5] = '{16'hF0E1, 1, 0, 64'h1_2345_6780, 777, 8'h06, 2};
    misc[6] = '{16'hF0E1, 0, 3, 64'h0_0000_1000, 128, 8'h07, 4};
    bp_en = 1'b1;
    foreach (misc[i])
      send_frame(misc[i].magic, misc[i].func, misc[i].slot, misc[i].addr, misc[i].len,
                 misc[i].tag, misc[i].nbeats, 1'b1, 1'b1, 20 + i, acc);
    wait_drain("drain_misc");
    check_stats("misc");

    wr_ready = 1'b0;
    fork
      send_frame(16'hF0E1, 0, 0, 64'h0_5555_0000, 300, 8'h77, 6, 1'b1, 1'b1, 11, acc);
      begin
        for (int n = 0; n < 200 && !wr_valid; n++) @(negedge clk);
        repeat (10) begin
          @(negedge clk);
          check_val("hold_valid", DW'(wr_valid), DW'(1));
          check_val("hold_fields", DW'({wr_addr, wr_len, wr_tag}), DW'({34'h0_5555_0000, 20'd300, 8'h77}));
          check_val("hold_s_ready", DW'(s_axis_tready), DW'(0));
        end
        @(posedge clk);
        #1;
        wr_ready = 1'b1;
      end
    join
    wait_drain("drain_hold");
    bp_en = 1'b0;

    send_frame(16'hF0E1, 0, 1, 64'h0_0000_2000, 200, 8'h44, 2, 1'b1, 1'b1, 12, acc);
    send_frame(16'hF0E1, 0, 1, 64'h0_0000_3000, 10, 8'h45, 2, 1'b1, 1'b1, 13, acc);
    wait_drain("drain_short");
    check_stats("short");

    wr_ready = 1'b0;
    send_frame(16'hF0E1, 0, 1, 64'h0_0000_4000, 300, 8'h46, 1, 1'b0, 1'b0, 14, acc);
    repeat (3) @(posedge clk);
    do_reset();
    wr_ready = 1'b1;
    send_frame(16'hF0E1, 2, 1, 64'h0, 1, 8'h47, 1, 1'b1, 1'b1, 15, acc);
    send_frame(16'hF0E1, 0, 0, 64'h0_0000_5000, 20, 8'h48, 2, 1'b1, 1'b1, 16, acc);
    wait_drain("drain_rst");
    check_stats("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/recon_dma_engine.md
RECON_DMA_ENGINE -- requirements
Module: recon_dma_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512: AXIS data width in bits; KEEP_WIDTH = DATA_WIDTH/8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 34: DMA descriptor address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 20: DMA descriptor length width.
REQ-004 SHALL have parameter TAG_WIDTH, default 8: DMA descriptor tag width.
REQ-005 SHALL have parameter HDR_OFFSET, default 46: byte offset of the recon header in the first beat; HDR_OFFSET+13 <= KEEP_WIDTH, else elaboration error.
REQ-006 SHALL have parameter MAGIC, default 16'hF0E1: recon header magic.
REQ-007 SHALL have parameter NUM_SLOTS, default 4, range 1..16: bitstream slot table entries.
REQ-008 Ports: clk in 1, the only clock; rst in 1, synchronous, active-high.
REQ-009 Input stream: s_axis_tdata in DATA_WIDTH; s_axis_tkeep in KEEP_WIDTH; s_axis_tvalid in 1; s_axis_tlast in 1; s_axis_tready out 1.
REQ-010 Read descriptor: m_axis_read_desc_addr out ADDR_WIDTH; _len out LEN_WIDTH; _tag out TAG_WIDTH; _valid out 1; _ready in 1.
REQ-011 Write descriptor: m_axis_write_desc_addr out ADDR_WIDTH; _len out LEN_WIDTH; _tag out TAG_WIDTH; _valid out 1; _ready in 1.
REQ-012 Output stream: m_axis_tdata out DATA_WIDTH; m_axis_tkeep out KEEP_WIDTH; m_axis_tvalid out 1; m_axis_tlast out 1; m_axis_tready in 1.
REQ-013 Status: stat_good_count out 16, accepted commands; stat_drop_count out 16, dropped frames; err_short out 1, one-cycle pulse on a truncated payload.

Function
REQ-014 Header bytes are relative to HDR_OFFSET, little-endian: [0:1] magic; [2] ctrl, with bits1:0 func and bits7:4 slot; [3:7] addr, low ADDR_WIDTH bits used; [8:11] len, low LEN_WIDTH bits used; [12] tag.
REQ-015 PAYLOAD_OFFSET = HDR_OFFSET+13; P1 = KEEP_WIDTH-PAYLOAD_OFFSET, the payload bytes carried in the first beat.
REQ-016 States: IDLE, DESC, PAYLOAD, FLUSH, DROP.
REQ-017 IDLE: s_axis_tready=1; the header is decoded from the first beat of each frame.
REQ-018 A first beat is dropped if the magic mismatches, func=11, len=0, or func=10 addresses an invalid or out-of-range slot.
REQ-019 On a drop: stat_drop_count+1; go to DROP if tlast=0, else stay in IDLE.
REQ-020 func=00 (write): load the write descriptor (addr, len, tag); store {addr,len,valid} in slot table[slot] (ignored if slot >= NUM_SLOTS); save the top P1 bytes; go to DESC.
REQ-021 func=01 (read): load the read descriptor from the header fields; go to DESC.
REQ-022 func=10 (read slot): load the read descriptor from slot table[slot] and the header tag; go to DESC.
REQ-023 DESC: s_axis_tready=0; desc_valid is held high with addr/len/tag stable until ready.
REQ-024 DESC exit on ready, with stat_good_count+1: write goes to PAYLOAD (FLUSH if len<=P1, or if the first beat had tlast); read goes to DROP if the first beat tlast=0, else to IDLE.
REQ-025 PAYLOAD: s_axis_tready = !m_axis_tvalid || m_axis_tready.
REQ-026 Each accepted beat in PAYLOAD registers one output beat: the saved P1 bytes in the low bytes, then the low KEEP_WIDTH-P1 bytes of the current beat. The top P1 bytes of the current beat are saved.
REQ-027 Output latency is 1 cycle after the input beat is accepted.
REQ-028 A remaining counter (LEN_WIDTH) starts at len and decrements by the bytes emitted per output beat.
REQ-029 An output beat with remaining <= KEEP_WIDTH sets tlast=1 and tkeep = low `remaining` bits set; all other beats use tkeep all-ones and tlast=0.
REQ-030 PAYLOAD exit when the saved bytes plus consumed bytes cover len: to FLUSH if saved bytes remain unsent, else to IDLE (input tlast=1) or DROP (input tlast=0).
REQ-031 FLUSH: s_axis_tready=0; emit the saved bytes as the final beat with tlast=1; then go to IDLE or DROP per the last input tlast.
REQ-032 Input tlast before len is covered: emit the available bytes with tlast=1, pulse err_short, return to IDLE after the output is accepted.
REQ-033 DROP: s_axis_tready=1; beats are discarded until tlast; then go to IDLE.
REQ-034 m_axis_tdata/tkeep/tlast SHALL be stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-035 Counters saturate at 16'hFFFF.
REQ-036 Input tkeep in the header beat is ignored.

Reset
REQ-037 rst=1 at a clock edge forces, the next cycle: state IDLE; all *_valid=0; s_axis_tready=0 during reset; counters=0; slot table all invalid; err_short=0; data/addr/len/tag outputs=0.
REQ-038 A reset mid-frame discards the frame silently; beats after reset are parsed as new frames.

Verification
REQ-039 Write of len=100 (DATA_WIDTH 512, P1=5), 3 input beats -> one write descriptor, addr as sent, len=100. Output is 2 beats: beat 1 tkeep all-ones; beat 2 tkeep=64'h0000000FFFFFFFFF with tlast=1; stat_good_count=1.
REQ-040 Wrong magic 16'h1234, 4-beat frame -> no descriptor and no output; stat_drop_count=1; all 4 beats accepted.
REQ-041 Write slot 2 (addr 0x1_0000_0000, len 4096), then func=10 slot 2 tag 0x5A -> read descriptor addr 0x1_0000_0000, len 4096, tag 0x5A.
REQ-042 func=10 slot 3, never written -> dropped; stat_drop_count+1; no read descriptor.
REQ-043 write_desc_ready held low for 10 cycles -> desc_valid stays high with fields stable; s_axis_tready=0; no data lost afterwards.
REQ-044 Write len=200 with tlast on beat 2 -> output ends after 69 bytes with tlast=1; err_short pulses once; the next frame parses normally.
